// File: rtl/asteroid_draw_scheduler.sv
// Per-frame sequencer for the shared draw_asteroid engine: walks the slot table on frame_start
// and issues one plot per active slot, waiting for draw_done (or a timeout) before moving on.
module asteroid_draw_scheduler #(
  parameter int NUM_SLOTS    = 16,
  parameter int SLOT_AW      = 4,
  parameter int DRAW_TIMEOUT = 2047
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic [SLOT_AW-1:0] slot_addr,
  input  logic               slot_active,
  input  logic [9:0]         slot_x,
  input  logic [9:0]         slot_y,
  input  logic [2:0]         slot_sprite,
  output logic               plot,
  output logic [9:0]         x_pos,
  output logic [9:0]         y_pos,
  output logic [2:0]         sprite_sel,
  input  logic               draw_done,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int                 CNT_W     = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DRAW_TIMEOUT);
  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLOT,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    plot       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:  if (frame_start) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = slot_active ? S_PLOT : S_NEXT;
      S_PLOT: begin
        plot    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  if (draw_done || wait_cnt == CNT_MAX) state_d = S_NEXT;
      S_NEXT:  state_d = (slot_addr == LAST_SLOT) ? S_DONE : S_FETCH;
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: slot address, held draw parameters, wait counter and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_addr   <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      sprite_sel  <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            slot_addr   <= '0;
            busy        <= 1'b1;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_LATCH: begin
          if (slot_active) begin
            x_pos      <= slot_x;
            y_pos      <= slot_y;
            sprite_sel <= slot_sprite;
          end
        end
        S_PLOT: wait_cnt <= '0;
        S_WAIT: begin
          // A completion arriving on the timeout cycle still counts as a good draw.
          if (!draw_done) begin
            if (wait_cnt == CNT_MAX) timeout_err <= 1'b1;
            else                     wait_cnt    <= wait_cnt + CNT_W'(1);
          end
        end
        S_NEXT:  if (slot_addr != LAST_SLOT) slot_addr <= slot_addr + SLOT_AW'(1);
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
      if (frame_start && state_q != S_IDLE) overrun <= 1'b1;
    end
  end

endmodule
